// File: rtl/game_referee_param_pkg.sv
// Shared types and defaults for the parametrised game referee.
// State encodings are fixed so the debug STATE output stays stable across builds.
package game_referee_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ARM  = 3'd2,
        ST_INV  = 3'd3,
        ST_NORM = 3'd4,
        ST_HURT = 3'd5,
        ST_RCV  = 3'd6,
        ST_OVER = 3'd7
    } state_e;

    localparam int DEF_INV_TICKS     = 250;
    localparam int DEF_RECOVER_TICKS = 500;

    // Only the live-play states react to TICK, HIT and PAUSE.
    function automatic logic is_play(input state_e st);
        return (st == ST_INV) || (st == ST_NORM);
    endfunction

endpackage

// File: rtl/game_referee_param_if.sv
// Control/status bundle between the game environment and the referee.
// The master side drives the game inputs; the referee is the slave.
interface game_referee_param_if
    import game_referee_param_pkg::*;
#(
    parameter int LIFE_W = 2
);
    logic              tick;
    logic              start;
    logic              game_ready;
    logic              pause;
    logic              hit;
    logic              hurt;
    logic              recover;
    logic              invincible;
    logic              over;
    logic [LIFE_W-1:0] life;
    state_e            state;

    modport master (
        output tick, start, game_ready, pause, hit,
        input  hurt, recover, invincible, over, life, state
    );

    modport slave (
        input  tick, start, game_ready, pause, hit,
        output hurt, recover, invincible, over, life, state
    );
endinterface

// File: rtl/game_referee_param_counter.sv
// Generic up-counter with enable and synchronous clear; clear has priority.
module game_referee_param_counter #(
    parameter int WIDTH = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q;

    // Count register: clear wins over enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {WIDTH{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {WIDTH{1'b0}};
        end else if (en_i) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/game_referee_param.sv
// Life-tracking game referee: start/invincible/normal/hurt/recover/over FSM
// with parametrised durations, pause, restart from OVER and a visible life count.
module game_referee_param
    import game_referee_param_pkg::*;
#(
    parameter int MAX_LIFE      = 3,
    parameter int START_LIFE    = 3,
    parameter int LIFE_W        = 2,
    parameter int INV_TICKS     = DEF_INV_TICKS,
    parameter int RECOVER_TICKS = DEF_RECOVER_TICKS,
    parameter int CNT_W         = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    game_referee_param_if.slave  bus
);
    // A phase ends on the tick that would bring the counter to its compare value.
    localparam logic [CNT_W-1:0]  INV_LAST = CNT_W'(INV_TICKS - 1);
    localparam logic [CNT_W-1:0]  INV_CAP  = CNT_W'(INV_TICKS);
    localparam logic [CNT_W-1:0]  RCV_LAST = CNT_W'(RECOVER_TICKS - 1);
    localparam logic [CNT_W-1:0]  RCV_CAP  = CNT_W'(RECOVER_TICKS);
    localparam logic [LIFE_W-1:0] LIFE_MAX = LIFE_W'(MAX_LIFE);
    localparam logic [LIFE_W-1:0] LIFE_INI = LIFE_W'(START_LIFE);

    state_e            state_q, state_d;
    logic [LIFE_W-1:0] life_q, life_d;
    logic [CNT_W-1:0]  cnt_s;
    logic              run_s;
    logic              tick_run_s;
    logic              cnt_en_s;
    logic              cnt_clr_s;

    assign run_s      = is_play(state_q) && !bus.pause;
    assign tick_run_s = run_s && bus.tick;

    game_referee_param_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr_s),
        .en_i   (cnt_en_s),
        .cnt_o  (cnt_s)
    );

    // Next-state decode; HIT has priority over recovery in NORM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_WAIT;
                else           state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.game_ready) state_d = ST_ARM;
                else                state_d = ST_WAIT;
            end
            ST_ARM:  state_d = ST_INV;
            ST_INV: begin
                if (tick_run_s && (cnt_s >= INV_LAST)) state_d = ST_NORM;
                else                                   state_d = ST_INV;
            end
            ST_NORM: begin
                if (run_s && bus.hit) begin
                    state_d = ST_HURT;
                end else if (tick_run_s && (cnt_s >= RCV_LAST) && (life_q < LIFE_MAX)) begin
                    state_d = ST_RCV;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_HURT: begin
                if (life_q == {LIFE_W{1'b0}}) state_d = ST_OVER;
                else                          state_d = ST_ARM;
            end
            ST_RCV:  state_d = ST_ARM;
            ST_OVER: begin
                if (bus.start) state_d = ST_WAIT;
                else           state_d = ST_OVER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Life updates happen on entry, so HURT already sees the decremented value.
    always_comb begin
        life_d = life_q;
        if (state_d == ST_WAIT && state_q != ST_WAIT) begin
            life_d = LIFE_INI;
        end else if (state_d == ST_HURT && state_q != ST_HURT) begin
            if (life_q == {LIFE_W{1'b0}}) life_d = {LIFE_W{1'b0}};
            else                          life_d = life_q - LIFE_W'(1);
        end else if (state_d == ST_RCV && state_q != ST_RCV) begin
            if (life_q < LIFE_MAX) life_d = life_q + LIFE_W'(1);
            else                   life_d = life_q;
        end else begin
            life_d = life_q;
        end
    end

    // Counter control: zero at INV and NORM entry, saturate at the phase limit.
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        if (state_q == ST_ARM) begin
            cnt_clr_s = 1'b1;
        end else if (state_q == ST_INV && state_d == ST_NORM) begin
            cnt_clr_s = 1'b1;
        end else begin
            cnt_clr_s = 1'b0;
        end
        if (tick_run_s && state_q == ST_INV && cnt_s < INV_CAP) begin
            cnt_en_s = 1'b1;
        end else if (tick_run_s && state_q == ST_NORM && cnt_s < RCV_CAP) begin
            cnt_en_s = 1'b1;
        end else begin
            cnt_en_s = 1'b0;
        end
    end

    // State and life registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            life_q  <= LIFE_INI;
        end else begin
            state_q <= state_d;
            life_q  <= life_d;
        end
    end

    assign bus.hurt       = (state_q == ST_HURT);
    assign bus.recover    = (state_q == ST_RCV);
    assign bus.invincible = (state_q == ST_ARM) || (state_q == ST_INV);
    assign bus.over       = (state_q == ST_OVER);
    assign bus.life       = life_q;
    assign bus.state      = state_q;
endmodule
